// File: rtl/reg_arbiter.sv
// Two-requester arbiter in front of a single-port register bank.
// Round-robin on ties; addresses at or above RO_BASE reject writes.
module reg_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter logic [ADDR_W-1:0] RO_BASE = 8'hF0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_done,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t            state;
    logic              owner;
    logic              last;
    logic              is_rd;
    logic              ro_err;
    logic              pick;
    logic              grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Tie goes to whoever was not served last; a lone requester always wins.
    assign pick      = r1_req & (~r0_req | ~last);
    assign grant     = rst & (state == IDLE) & (r0_req | r1_req);
    assign r0_gnt    = grant & ~pick;
    assign r1_gnt    = grant & pick;
    assign sel_we    = pick ? r1_we : r0_we;
    assign sel_addr  = pick ? r1_addr : r0_addr;
    assign sel_wdata = pick ? r1_wdata : r0_wdata;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            owner          <= 1'b0;
            last           <= 1'b1;
            is_rd          <= 1'b0;
            ro_err         <= 1'b0;
            r0_done        <= 1'b0;
            r1_done        <= 1'b0;
            r0_err         <= 1'b0;
            r1_err         <= 1'b0;
            r0_rdata       <= '0;
            r1_rdata       <= '0;
            mem_write_en   <= 1'b0;
            mem_read_en    <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            r0_done        <= 1'b0;
            r1_done        <= 1'b0;
            r0_err         <= 1'b0;
            r1_err         <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_read_en    <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        owner          <= pick;
                        last           <= pick;
                        is_rd          <= ~sel_we;
                        ro_err         <= sel_we & (sel_addr >= RO_BASE);
                        mem_addr       <= sel_addr;
                        mem_write_data <= sel_wdata;
                        mem_write_en   <= sel_we & (sel_addr < RO_BASE);
                        mem_read_en    <= ~sel_we;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (is_rd) begin
                        state <= WAIT;
                    end else begin
                        if (owner) begin
                            r1_done <= 1'b1;
                            r1_err  <= ro_err;
                        end else begin
                            r0_done <= 1'b1;
                            r0_err  <= ro_err;
                        end
                        state <= DONE;
                    end
                end
                WAIT: begin
                    if (owner) begin
                        r1_done  <= 1'b1;
                        r1_rdata <= mem_read_data;
                    end else begin
                        r0_done  <= 1'b1;
                        r0_rdata <= mem_read_data;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_arbiter.sv
// Randomized self-checking bench for reg_arbiter.
// Expected behaviour comes from a transaction-level schedule model.
module tb_reg_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       r0_req = 1'b0;
    logic       r0_we = 1'b0;
    logic [7:0] r0_addr = '0;
    logic [7:0] r0_wdata = '0;
    logic       r1_req = 1'b0;
    logic       r1_we = 1'b0;
    logic [7:0] r1_addr = '0;
    logic [7:0] r1_wdata = '0;
    logic       r0_gnt, r0_done, r0_err;
    logic [7:0] r0_rdata;
    logic       r1_gnt, r1_done, r1_err;
    logic [7:0] r1_rdata;
    logic       mem_write_en, mem_read_en, busy;
    logic [7:0] mem_addr, mem_write_data;
    logic [7:0] mem_read_data;

    always #5 clk = ~clk;

    reg_arbiter #(
        .ADDR_W(8),
        .DATA_W(8),
        .RO_BASE(8'hF0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .r0_req(r0_req),
        .r0_we(r0_we),
        .r0_addr(r0_addr),
        .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt),
        .r0_done(r0_done),
        .r0_err(r0_err),
        .r0_rdata(r0_rdata),
        .r1_req(r1_req),
        .r1_we(r1_we),
        .r1_addr(r1_addr),
        .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt),
        .r1_done(r1_done),
        .r1_err(r1_err),
        .r1_rdata(r1_rdata),
        .mem_write_en(mem_write_en),
        .mem_read_en(mem_read_en),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .busy(busy)
    );

    // Register bank environment: one-cycle read latency, garbage otherwise.
    logic [7:0] init_img [256];
    logic [7:0] bank [256];
    bit         loaded;

    always @(posedge clk) begin
        if (!loaded) begin
            bank   <= init_img;
            loaded <= 1'b1;
        end else if (mem_write_en) begin
            bank[mem_addr] <= mem_write_data;
        end
        if (mem_read_en) mem_read_data <= bank[mem_addr];
        else mem_read_data <= 8'($urandom);
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        bit         wr;
        logic [7:0] a;
        logic [7:0] d;
    } strobe_t;

    strobe_t    sq[$];
    strobe_t    esq[$];
    int         o_ngnt[2], o_g[2], o_ndone[2], o_d[2], o_busy_last;
    bit         o_err[2], o_ovl;
    logic [7:0] o_rd[2];
    int         e_ngnt[2], e_g[2], e_d[2], e_busy_last;
    bit         e_err[2];
    logic [7:0] e_rd[2];
    logic [7:0] ref_mem [256];
    bit         ref_last;
    logic [7:0] ref_hold[2];

    // Drives one or two requests, drops each req after its grant, logs 16 cycles.
    task automatic run_pair(input bit v0, input bit v1,
                            input bit we0, input bit we1,
                            input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] d0, input logic [7:0] d1);
        bit g0, g1;
        sq.delete();
        o_ovl = 0;
        o_busy_last = -1;
        for (int i = 0; i < 2; i++) begin
            o_ngnt[i] = 0; o_g[i] = -1; o_ndone[i] = 0;
            o_d[i] = -1; o_err[i] = 0; o_rd[i] = '0;
        end
        r0_req = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
        r1_req = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            g0 = r0_gnt;
            g1 = r1_gnt;
            if (g0) begin o_ngnt[0]++; o_g[0] = c; end
            if (g1) begin o_ngnt[1]++; o_g[1] = c; end
            if (mem_write_en && mem_read_en) o_ovl = 1;
            if (g0 && g1) o_ovl = 1;
            if (mem_write_en || mem_read_en)
                sq.push_back('{c, mem_write_en, mem_addr,
                               mem_write_en ? mem_write_data : 8'h00});
            if (r0_done) begin
                o_ndone[0]++; o_d[0] = c; o_err[0] = r0_err; o_rd[0] = r0_rdata;
            end
            if (r1_done) begin
                o_ndone[1]++; o_d[1] = c; o_err[1] = r1_err; o_rd[1] = r1_rdata;
            end
            if (busy) o_busy_last = c;
            @(posedge clk);
            #1;
            if (g0) r0_req = 0;
            if (g1) r1_req = 0;
        end
        r0_req = 0;
        r1_req = 0;
    endtask

    // Reference: serve requests one at a time in round-robin order;
    // a write finishes two cycles after its grant, a read three, and the
    // next grant follows the cycle after completion.
    task automatic model_apply(input bit v0, input bit v1,
                               input bit we0, input bit we1,
                               input logic [7:0] a0, input logic [7:0] a1,
                               input logic [7:0] d0, input logic [7:0] d1);
        int         ord[$];
        int         t, n;
        bit         w[2];
        logic [7:0] a[2], d[2];
        w[0] = we0; w[1] = we1; a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        esq.delete();
        for (int i = 0; i < 2; i++) begin
            e_ngnt[i] = 0; e_g[i] = -1; e_d[i] = -1; e_err[i] = 0; e_rd[i] = '0;
        end
        if (v0 && v1) begin
            n = ref_last ? 0 : 1;
            ord.push_back(n);
            ord.push_back(1 - n);
        end else if (v0) begin
            ord.push_back(0);
        end else if (v1) begin
            ord.push_back(1);
        end
        t = 0;
        foreach (ord[k]) begin
            n = ord[k];
            e_ngnt[n] = 1;
            e_g[n] = t;
            if (w[n]) begin
                if (a[n] >= 8'hF0) e_err[n] = 1;
                else begin
                    esq.push_back('{t + 1, 1'b1, a[n], d[n]});
                    ref_mem[a[n]] = d[n];
                end
                e_d[n] = t + 2;
            end else begin
                esq.push_back('{t + 1, 1'b0, a[n], 8'h00});
                e_rd[n] = ref_mem[a[n]];
                ref_hold[n] = ref_mem[a[n]];
                e_d[n] = t + 3;
            end
            t = e_d[n] + 1;
            ref_last = n[0];
        end
        e_busy_last = (ord.size() > 0) ? t - 1 : -1;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err,
             mem_write_en, mem_read_en, busy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0", {r0_gnt, r1_gnt,
                     r0_done, r1_done, r0_err, r1_err, mem_write_en,
                     mem_read_en, busy});
        end
        checks++;
        if ({mem_addr, mem_write_data, r0_rdata, r1_rdata} !== 32'd0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0",
                     {mem_addr, mem_write_data, r0_rdata, r1_rdata});
        end
        @(posedge clk);
        #1;
        rst = 1;
        ref_last = 1;
        ref_hold[0] = '0;
        ref_hold[1] = '0;
    endtask

    task automatic test_write();
        model_apply(1, 0, 1, 0, 8'h10, 8'h00, 8'hA5, 8'h00);
        run_pair(1, 0, 1, 0, 8'h10, 8'h00, 8'hA5, 8'h00);
        checks++;
        if (o_g[0] !== 0) begin
            errors++; $display("FAIL wr_gnt got %0d exp 0", o_g[0]);
        end
        checks++;
        if (sq.size() !== 1) begin
            errors++; $display("FAIL wr_strobes got %0d exp 1", sq.size());
        end else begin
            checks++;
            if ({sq[0].cyc[7:0], 7'd0, sq[0].wr, sq[0].a, sq[0].d}
                !== {8'd1, 8'd1, 8'h10, 8'hA5}) begin
                errors++;
                $display("FAIL wr_strobe got c%0d w%0d a%h d%h exp c1 w1 a10 dA5",
                         sq[0].cyc, sq[0].wr, sq[0].a, sq[0].d);
            end
        end
        checks++;
        if (o_d[0] !== 2 || o_err[0] !== 1'b0 || o_ndone[0] !== 1) begin
            errors++;
            $display("FAIL wr_done got c%0d err%0d n%0d exp c2 err0 n1",
                     o_d[0], o_err[0], o_ndone[0]);
        end
        checks++;
        if (o_busy_last !== 2) begin
            errors++; $display("FAIL wr_idle got %0d exp 2", o_busy_last);
        end
    endtask

    task automatic test_read();
        model_apply(0, 1, 0, 0, 8'h00, 8'h10, 8'h00, 8'h00);
        run_pair(0, 1, 0, 0, 8'h00, 8'h10, 8'h00, 8'h00);
        checks++;
        if (sq.size() !== 1) begin
            errors++; $display("FAIL rd_strobes got %0d exp 1", sq.size());
        end else begin
            checks++;
            if (sq[0].cyc !== 1 || sq[0].wr !== 1'b0 || sq[0].a !== 8'h10) begin
                errors++;
                $display("FAIL rd_strobe got c%0d w%0d a%h exp c1 w0 a10",
                         sq[0].cyc, sq[0].wr, sq[0].a);
            end
        end
        checks++;
        if (o_d[1] !== 3 || o_rd[1] !== 8'hA5) begin
            errors++;
            $display("FAIL rd_done got c%0d d%h exp c3 dA5", o_d[1], o_rd[1]);
        end
        checks++;
        if (r0_rdata !== 8'h00 || o_ndone[0] !== 0) begin
            errors++;
            $display("FAIL rd_other got %h n%0d exp 00 n0", r0_rdata, o_ndone[0]);
        end
        checks++;
        if (o_busy_last !== 3) begin
            errors++; $display("FAIL rd_idle got %0d exp 3", o_busy_last);
        end
    endtask

    task automatic test_ro_write();
        logic [7:0] old;
        old = ref_mem[8'hF3];
        model_apply(0, 1, 0, 1, 8'h00, 8'hF3, 8'h00, 8'h55);
        run_pair(0, 1, 0, 1, 8'h00, 8'hF3, 8'h00, 8'h55);
        checks++;
        if (sq.size() !== 0) begin
            errors++; $display("FAIL ro_strobes got %0d exp 0", sq.size());
        end
        checks++;
        if (o_d[1] !== 2 || o_err[1] !== 1'b1) begin
            errors++;
            $display("FAIL ro_done got c%0d err%0d exp c2 err1", o_d[1], o_err[1]);
        end
        model_apply(1, 0, 0, 0, 8'hF3, 8'h00, 8'h00, 8'h00);
        run_pair(1, 0, 0, 0, 8'hF3, 8'h00, 8'h00, 8'h00);
        checks++;
        if (o_d[0] !== 3 || o_rd[0] !== old) begin
            errors++;
            $display("FAIL ro_readback got c%0d d%h exp c3 d%h", o_d[0], o_rd[0], old);
        end
    endtask

    task automatic test_alternate();
        int gc[$];
        int gw[$];
        bit ovl;
        bit first;
        first = ~ref_last;
        ovl = 0;
        r0_we = 0; r0_addr = 8'h12;
        r1_we = 0; r1_addr = 8'hF1;
        r0_req = 1; r1_req = 1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (r0_gnt) begin gc.push_back(c); gw.push_back(0); end
            if (r1_gnt) begin gc.push_back(c); gw.push_back(1); end
            if (mem_write_en && mem_read_en) ovl = 1;
            @(posedge clk);
            #1;
        end
        r0_req = 0; r1_req = 0;
        checks++;
        if (gc.size() !== 6) begin
            errors++; $display("FAIL alt_count got %0d exp 6", gc.size());
        end
        foreach (gc[k]) begin
            checks++;
            if (gc[k] !== 4 * k || gw[k] !== int'(first ^ k[0])) begin
                errors++;
                $display("FAIL alt_gnt%0d got c%0d r%0d exp c%0d r%0d",
                         k, gc[k], gw[k], 4 * k, first ^ k[0]);
            end
        end
        checks++;
        if (ovl) begin
            errors++; $display("FAIL alt_overlap got 1 exp 0");
        end
        checks++;
        if (r0_rdata !== ref_mem[8'h12] || r1_rdata !== ref_mem[8'hF1]) begin
            errors++;
            $display("FAIL alt_rdata got %h %h exp %h %h", r0_rdata, r1_rdata,
                     ref_mem[8'h12], ref_mem[8'hF1]);
        end
        ref_hold[0] = ref_mem[8'h12];
        ref_hold[1] = ref_mem[8'hF1];
        ref_last = ~first;
    endtask

    task automatic test_ignored_pulse();
        int  n_g0, n_str, d1;
        bit  g1;
        n_g0 = 0; n_str = 0; d1 = -1;
        r1_we = 1; r1_addr = 8'h22; r1_wdata = 8'h3C; r1_req = 1;
        r0_we = 0; r0_addr = 8'h10;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) r0_req = 1;
            if (c == 3) r0_req = 0;
            @(negedge clk);
            g1 = r1_gnt;
            if (r0_gnt) n_g0++;
            if (mem_write_en || mem_read_en) n_str++;
            if (r1_done) d1 = c;
            @(posedge clk);
            #1;
            if (g1) r1_req = 0;
        end
        r1_req = 0;
        model_apply(0, 1, 0, 1, 8'h00, 8'h22, 8'h00, 8'h3C);
        checks++;
        if (n_g0 !== 0 || n_str !== 1) begin
            errors++;
            $display("FAIL pulse_ignored got g%0d s%0d exp g0 s1", n_g0, n_str);
        end
        checks++;
        if (d1 !== 2) begin
            errors++; $display("FAIL pulse_done got %0d exp 2", d1);
        end
    endtask

    task automatic test_reset_mid_read();
        int nd;
        int g0c;
        bit g0;
        nd = 0;
        g0c = -1;
        r0_we = 0; r0_addr = 8'h10; r0_req = 1;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) rst = 0;
            if (c == 4) rst = 1;
            @(negedge clk);
            g0 = r0_gnt;
            if (g0) g0c = c;
            if (r0_done || r1_done) nd++;
            if (c == 3 || c == 4) begin
                checks++;
                if ({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err,
                     mem_write_en, mem_read_en, busy, mem_addr,
                     mem_write_data, r0_rdata, r1_rdata} !== 41'd0) begin
                    errors++;
                    $display("FAIL midrst_outs c%0d busy%0d rd%h exp all 0",
                             c, busy, r0_rdata);
                end
            end
            @(posedge clk);
            #1;
            if (g0) r0_req = 0;
        end
        checks++;
        if (nd !== 0 || g0c !== 0) begin
            errors++;
            $display("FAIL midrst_done got n%0d g%0d exp n0 g0", nd, g0c);
        end
        ref_last = 1;
        ref_hold[0] = '0;
        ref_hold[1] = '0;
        model_apply(1, 1, 0, 1, 8'h13, 8'h14, 8'h00, 8'h77);
        run_pair(1, 1, 0, 1, 8'h13, 8'h14, 8'h00, 8'h77);
        checks++;
        if (o_g[0] !== 0 || o_g[1] !== e_g[1]) begin
            errors++;
            $display("FAIL midrst_tie got %0d %0d exp 0 %0d", o_g[0], o_g[1], e_g[1]);
        end
    endtask

    task automatic test_random();
        bit         v0, v1, we0, we1;
        logic [7:0] a0, a1, d0, d1;
        int         p;
        for (int it = 0; it < 25; it++) begin
            p = int'($urandom_range(1, 3));
            v0 = p[0]; v1 = p[1];
            we0 = 1'($urandom_range(0, 1));
            we1 = 1'($urandom_range(0, 1));
            a0 = ($urandom_range(0, 3) == 0) ? 8'(8'hF0 + $urandom_range(0, 15))
                                             : 8'(8'h10 + $urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? 8'(8'hF0 + $urandom_range(0, 15))
                                             : 8'(8'h10 + $urandom_range(0, 7));
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            model_apply(v0, v1, we0, we1, a0, a1, d0, d1);
            run_pair(v0, v1, we0, we1, a0, a1, d0, d1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (o_ngnt[i] !== e_ngnt[i] || o_g[i] !== e_g[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_gnt%0d got n%0d c%0d exp n%0d c%0d",
                             it, i, o_ngnt[i], o_g[i], e_ngnt[i], e_g[i]);
                end
                checks++;
                if (o_ndone[i] !== e_ngnt[i] || o_d[i] !== e_d[i]
                    || o_err[i] !== e_err[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_done%0d got n%0d c%0d e%0d exp n%0d c%0d e%0d",
                             it, i, o_ndone[i], o_d[i], o_err[i],
                             e_ngnt[i], e_d[i], e_err[i]);
                end
                if (e_ngnt[i] == 1 && ((i == 0) ? !we0 : !we1)) begin
                    checks++;
                    if (o_rd[i] !== e_rd[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_rdata%0d got %h exp %h",
                                 it, i, o_rd[i], e_rd[i]);
                    end
                end
            end
            checks++;
            if (r0_rdata !== ref_hold[0] || r1_rdata !== ref_hold[1]) begin
                errors++;
                $display("FAIL rnd%0d_hold got %h %h exp %h %h", it,
                         r0_rdata, r1_rdata, ref_hold[0], ref_hold[1]);
            end
            checks++;
            if (sq.size() !== esq.size() || o_ovl) begin
                errors++;
                $display("FAIL rnd%0d_strobes got n%0d ovl%0d exp n%0d ovl0",
                         it, sq.size(), o_ovl, esq.size());
            end else begin
                foreach (sq[j]) begin
                    checks++;
                    if (sq[j].cyc !== esq[j].cyc || sq[j].wr !== esq[j].wr
                        || sq[j].a !== esq[j].a || sq[j].d !== esq[j].d) begin
                        errors++;
                        $display("FAIL rnd%0d_strobe%0d got c%0d w%0d a%h d%h exp c%0d w%0d a%h d%h",
                                 it, j, sq[j].cyc, sq[j].wr, sq[j].a, sq[j].d,
                                 esq[j].cyc, esq[j].wr, esq[j].a, esq[j].d);
                    end
                end
            end
            checks++;
            if (o_busy_last !== e_busy_last) begin
                errors++;
                $display("FAIL rnd%0d_busy got %0d exp %0d", it,
                         o_busy_last, e_busy_last);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            init_img[i] = 8'($urandom);
            ref_mem[i]  = init_img[i];
        end
        test_reset();
        test_write();
        test_read();
        test_ro_write();
        test_alternate();
        test_ignored_pulse();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
